// File: rtl/seven_seg_reader.sv
// rtl/seven_seg_reader.sv - decodes a stable two-digit 7-segment pair back to BCD and binary.
// Optional leading-zero blanking on the tens digit is enabled by defining BLANK_TENS_EN.
`timescale 1ns/1ps

module seven_seg_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg2,
    input  logic [6:0] seg1,
    output logic [6:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       valid,
    output logic       err,
    output logic       locked
);

    // Glyphs are compared and decoded in active-low form regardless of board polarity.
    localparam logic [6:0] UNLIT     = 7'b1111111;
    localparam logic [6:0] UNLIT_RAW = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
    localparam logic [7:0] LAST      = 8'(STABLE_CYCLES - 1);

    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [13:0] meta;
    logic [13:0] sync;
    logic [13:0] pair;
    logic [13:0] cand;
    logic [7:0]  count;
    logic        cand_load;
    logic        cnt_inc;
    logic        do_lock;
    logic [4:0]  tens_dec;
    logic [4:0]  ones_dec;
    logic [6:0]  t_ext;
    logic [6:0]  o_ext;
    logic [6:0]  bin_calc;

    // Returns {ok, digit}; ok=0 for blank, hex letters and any malformed glyph.
    function automatic logic [4:0] decode(input logic [6:0] g);
        case (g)
            7'b1000000: return {1'b1, 4'd0};
            7'b1111001: return {1'b1, 4'd1};
            7'b0100100: return {1'b1, 4'd2};
            7'b0110000: return {1'b1, 4'd3};
            7'b0011001: return {1'b1, 4'd4};
            7'b0010010: return {1'b1, 4'd5};
            7'b0000010: return {1'b1, 4'd6};
            7'b1111000: return {1'b1, 4'd7};
            7'b0000000: return {1'b1, 4'd8};
            7'b0010000: return {1'b1, 4'd9};
            default:    return 5'b0_0000;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= {UNLIT_RAW, UNLIT_RAW};
            sync <= {UNLIT_RAW, UNLIT_RAW};
        end else begin
            meta <= {seg2, seg1};
            sync <= meta;
        end
    end

    assign pair = ACTIVE_LOW ? sync : ~sync;

    always_comb begin
        tens_dec = decode(pair[13:7]);
        ones_dec = decode(pair[6:0]);
`ifdef BLANK_TENS_EN
        if (pair[13:7] == UNLIT) begin
            tens_dec = {1'b1, 4'd0};
        end
`endif
    end

    // tens*10 + ones as (t<<3)+(t<<1)+o
    assign t_ext    = {3'b000, tens_dec[3:0]};
    assign o_ext    = {3'b000, ones_dec[3:0]};
    assign bin_calc = (t_ext << 3) + (t_ext << 1) + o_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SETTLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cand_load = 1'b0;
        cnt_inc   = 1'b0;
        do_lock   = 1'b0;
        case (state)
            SETTLE: begin
                // A change always restarts the window, even on the expiring cycle.
                if (pair != cand) begin
                    cand_load = 1'b1;
                end else if (count >= LAST) begin
                    state_nxt = LOCKED;
                    do_lock   = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            LOCKED: begin
                if (pair != cand) begin
                    cand_load = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            default: begin
                state_nxt = SETTLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand  <= {UNLIT, UNLIT};
            count <= 8'd0;
        end else if (cand_load) begin
            cand  <= pair;
            count <= 8'd0;
        end else if (cnt_inc) begin
            count <= count + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin   <= 7'd0;
            tens  <= 4'd0;
            ones  <= 4'd0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (do_lock) begin
                if (tens_dec[4] && ones_dec[4]) begin
                    tens  <= tens_dec[3:0];
                    ones  <= ones_dec[3:0];
                    bin   <= bin_calc;
                    err   <= 1'b0;
                    valid <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule
